// File: rtl/led_target_tracker_pkg.sv
// Shared types for the LED target tracker: game states, level codes and the slot record.
package led_target_tracker_pkg;

  localparam int unsigned IdxW = 5;
  localparam int unsigned CntW = 32;

  typedef logic [0:0] game_state_t;
  localparam game_state_t StPlay = 1'b0;
  localparam game_state_t StOver = 1'b1;

  localparam logic [1:0] LvlSlow = 2'b00;
  localparam logic [1:0] LvlMid  = 2'b01;
  localparam logic [1:0] LvlFast = 2'b10;

  typedef struct packed {
    logic            valid;
    logic [IdxW-1:0] idx;
    logic [CntW-1:0] cnt;
  } slot_t;

  // Countdown load value: a slot stays lit for exactly the selected lifetime.
  function automatic logic [CntW-1:0] life_for_level(input logic [1:0]  lvl,
                                                     input int unsigned l0,
                                                     input int unsigned l1,
                                                     input int unsigned l2);
    int unsigned life;
    case (lvl)
      LvlMid:  life = l1;
      LvlFast: life = l2;
      default: life = l0;
    endcase
    return life - 32'd1;
  endfunction

endpackage

// File: rtl/led_target_tracker_sw_edge_detect.sv
// Per-bit rising-edge detector for the player switches.
// Define SW_SYNC_EN to insert a two-flop synchronizer ahead of the edge detector.
module sw_edge_detect #(
  parameter int unsigned Width = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] sw_i,
  output logic [Width-1:0] rise_o
);

`ifdef SW_SYNC_EN
  logic [Width-1:0] sync1_q, sync2_q, hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign rise_o = sync2_q & ~hist_q;
`else
  logic [Width-1:0] hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
    end else begin
      hist_q <= sw_i;
    end
  end

  assign rise_o = sw_i & ~hist_q;
`endif

endmodule

// File: rtl/led_target_tracker.sv
// Whack-a-mole style target tracker: lights requested LEDs, scores hits, counts misses.
// Build option SW_SYNC_EN adds a two-flop switch synchronizer (see sw_edge_detect).
module led_target_tracker
  import led_target_tracker_pkg::*;
#(
  parameter int unsigned LED_COUNT  = 18,
  parameter int unsigned SLOTS      = 4,
  parameter int unsigned LIFE0      = 60_000_000,
  parameter int unsigned LIFE1      = 30_000_000,
  parameter int unsigned LIFE2      = 15_000_000,
  parameter int unsigned MAX_MISSES = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           level_i,
  input  logic                 led_request_i,
  input  logic [IdxW-1:0]      led_index_i,
  input  logic [LED_COUNT-1:0] sw_i,
  output logic [LED_COUNT-1:0] ledr_o,
  output logic [15:0]          score_o,
  output logic [7:0]           misses_o,
  output logic                 hit_pulse_o,
  output logic                 miss_pulse_o,
  output logic                 game_over_o
);

  logic [LED_COUNT-1:0] rise;
  logic [31:0]          rise_w, lit_w, onehot;
  slot_t                slots_q [SLOTS];
  slot_t                slots_d [SLOTS];
  logic [LED_COUNT-1:0] ledr_q, ledr_d;
  logic [15:0]          score_q, score_d;
  logic [7:0]           misses_q, misses_d;
  logic                 hit_q, hit_d, miss_q, miss_d;
  game_state_t          state_q, state_d;
  logic [7:0]           hits, miss_cnt;
  logic [16:0]          score_sum;
  logic [8:0]           miss_sum;
  logic                 req_ok, placed;

  sw_edge_detect #(
    .Width(LED_COUNT)
  ) u_sw_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sw_i  (sw_i),
    .rise_o(rise)
  );

  // ledr_q mirrors the slot table, so it doubles as the start-of-cycle "lit" map.
  assign rise_w = 32'(rise);
  assign lit_w  = 32'(ledr_q);

  always_comb begin
    slots_d  = slots_q;
    hits     = '0;
    miss_cnt = '0;
    placed   = 1'b0;
    onehot   = '0;
    ledr_d   = '0;
    req_ok   = led_request_i && (32'(led_index_i) < LED_COUNT) && !lit_w[led_index_i];

    for (int unsigned s = 0; s < SLOTS; s++) begin
      if (slots_q[s].valid) begin
        // A press wins over a timeout on the same slot.
        if (rise_w[slots_q[s].idx]) begin
          slots_d[s].valid = 1'b0;
          hits             = hits + 8'd1;
        end else if (slots_q[s].cnt == '0) begin
          slots_d[s].valid = 1'b0;
          miss_cnt         = miss_cnt + 8'd1;
        end else begin
          slots_d[s].cnt = slots_q[s].cnt - 32'd1;
        end
      end else if (req_ok && !placed) begin
        slots_d[s] = '{valid: 1'b1, idx: led_index_i,
                       cnt: life_for_level(level_i, LIFE0, LIFE1, LIFE2)};
        placed     = 1'b1;
      end
    end

    for (int unsigned i = 0; i < LED_COUNT; i++) begin
      if (rise[i] && !ledr_q[i]) miss_cnt = miss_cnt + 8'd1;
    end

    score_sum = {1'b0, score_q} + {9'd0, hits};
    miss_sum  = {1'b0, misses_q} + {1'b0, miss_cnt};
    score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    misses_d  = (miss_sum >= 9'(MAX_MISSES)) ? 8'(MAX_MISSES) : miss_sum[7:0];
    hit_d     = (hits != '0);
    miss_d    = (miss_cnt != '0);
    state_d   = (misses_d >= 8'(MAX_MISSES)) ? StOver : StPlay;

    if (state_q == StOver) begin
      score_d  = score_q;
      misses_d = misses_q;
      hit_d    = 1'b0;
      miss_d   = 1'b0;
      state_d  = StOver;
    end

    if (state_d == StOver) begin
      for (int unsigned s = 0; s < SLOTS; s++) slots_d[s] = '0;
    end

    for (int unsigned s = 0; s < SLOTS; s++) begin
      if (slots_d[s].valid) begin
        onehot = 32'd1 << slots_d[s].idx;
        ledr_d = ledr_d | onehot[LED_COUNT-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < SLOTS; s++) slots_q[s] <= '0;
      ledr_q   <= '0;
      score_q  <= '0;
      misses_q <= '0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      state_q  <= StPlay;
    end else begin
      for (int unsigned s = 0; s < SLOTS; s++) slots_q[s] <= slots_d[s];
      ledr_q   <= ledr_d;
      score_q  <= score_d;
      misses_q <= misses_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      state_q  <= state_d;
    end
  end

  assign ledr_o       = ledr_q;
  assign score_o      = score_q;
  assign misses_o     = misses_q;
  assign hit_pulse_o  = hit_q;
  assign miss_pulse_o = miss_q;
  assign game_over_o  = (state_q == StOver);

endmodule

// File: tb/tb_led_target_tracker.sv
// Bench for led_target_tracker: directed scenarios plus random play against an event-level model.
module tb_led_target_tracker;

  localparam int Led  = 18;
  localparam int Slots = 4;
  localparam int MaxM = 5;
`ifdef SW_SYNC_EN
  localparam int Lat = 3;
`else
  localparam int Lat = 1;
`endif
  localparam int Dly = Lat - 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [1:0]     level = 2'b00;
  logic           led_request = 1'b0;
  logic [4:0]     led_index = '0;
  logic [Led-1:0] sw_r = '0;
  logic [Led-1:0] ledr;
  logic [15:0]    score;
  logic [7:0]     misses;
  logic           hit_pulse, miss_pulse, game_over;

  led_target_tracker #(
    .LED_COUNT(Led), .SLOTS(Slots), .LIFE0(20), .LIFE1(9), .LIFE2(14), .MAX_MISSES(MaxM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .level_i(level), .led_request_i(led_request),
    .led_index_i(led_index), .sw_i(sw_r), .ledr_o(ledr), .score_o(score), .misses_o(misses),
    .hit_pulse_o(hit_pulse), .miss_pulse_o(miss_pulse), .game_over_o(game_over)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each LED carries an absolute expiry time; only the count of lit LEDs limits slots.
  bit             m_lit [32];
  int             m_exp [32];
  bit             m_clr [32];
  int             m_score, m_miss, now, m_h, m_m, m_nlit;
  bit             m_hp, m_mp, m_over, m_take;
  logic [Led-1:0] swh [4];
  logic [Led-1:0] m_rise;

  function automatic int life_of(input logic [1:0] l);
    return (l == 2'b01) ? 9 : (l == 2'b10) ? 14 : 20;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m_lit[i] = 1'b0;
        m_exp[i] = 0;
      end
      for (int k = 0; k < 4; k++) swh[k] = '0;
      m_score = 0; m_miss = 0; now = 0;
      m_hp = 1'b0; m_mp = 1'b0; m_over = 1'b0;
    end else begin
      now++;
      for (int k = 3; k > 0; k--) swh[k] = swh[k-1];
      swh[0] = sw_r;
      m_rise = swh[Dly] & ~swh[Dly+1];
      if (m_over) begin
        m_hp = 1'b0;
        m_mp = 1'b0;
      end else begin
        m_h = 0; m_m = 0; m_nlit = 0;
        for (int i = 0; i < Led; i++) begin
          m_clr[i] = 1'b0;
          if (m_lit[i]) m_nlit++;
        end
        m_take = led_request && (int'(led_index) < Led) && !m_lit[led_index] && (m_nlit < Slots);
        for (int i = 0; i < Led; i++) begin
          if (m_rise[i]) begin
            if (m_lit[i]) begin
              m_h++;
              m_clr[i] = 1'b1;
            end else m_m++;
          end else if (m_lit[i] && m_exp[i] == now) begin
            m_m++;
            m_clr[i] = 1'b1;
          end
        end
        for (int i = 0; i < Led; i++) if (m_clr[i]) m_lit[i] = 1'b0;
        if (m_take) begin
          m_lit[led_index] = 1'b1;
          m_exp[led_index] = now + life_of(level);
        end
        m_score = (m_score + m_h > 65535) ? 65535 : m_score + m_h;
        m_miss  = (m_miss + m_m > MaxM) ? MaxM : m_miss + m_m;
        m_hp    = (m_h > 0);
        m_mp    = (m_m > 0);
        if (m_miss >= MaxM) begin
          m_over = 1'b1;
          for (int i = 0; i < 32; i++) m_lit[i] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] mv;
    mv = '0;
    for (int i = 0; i < Led; i++) if (m_lit[i]) mv[i] = 1'b1;
    check("model_ledr", 32'(ledr), mv);
    check("model_score", 32'(score), m_score);
    check("model_misses", 32'(misses), m_miss);
    check("model_hit_pulse", 32'(hit_pulse), 32'(m_hp));
    check("model_miss_pulse", 32'(miss_pulse), 32'(m_mp));
    check("model_game_over", 32'(game_over), 32'(m_over));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    sw_r = '0;
    led_request = 1'b0;
    #1;
    check("rst_ledr", 32'(ledr), 0);
    check("rst_score", 32'(score), 0);
    check("rst_misses", 32'(misses), 0);
    check("rst_over", 32'(game_over), 0);
    check("rst_pulses", {30'd0, hit_pulse, miss_pulse}, 0);
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic request(input int idx, input logic [1:0] lvl);
    led_request = 1'b1;
    led_index   = 5'(idx);
    level       = lvl;
    @(negedge clk);
    led_request = 1'b0;
  endtask

  initial begin
    int n, b;
    // Hit on a fast-level target, with press latency measured.
    do_reset();
    request(5, 2'b10);
    check("t034_lit", 32'(ledr[5]), 1);
    tick(8);
    sw_r[5] = 1'b1;
    n = 0;
    while (n < 10 && ledr[5]) begin
      @(negedge clk);
      n++;
    end
    check("t039_press_latency", n, Lat);
    check("t034_score", 32'(score), 1);
    check("t034_hit_pulse", 32'(hit_pulse), 1);
    sw_r[5] = 1'b0;
    tick(1);
    check("t034_hit_pulse_off", 32'(hit_pulse), 0);

    // Timeout after exactly LIFE0 cycles.
    do_reset();
    request(3, 2'b00);
    n = 0;
    while (n < 40 && ledr[3]) begin
      @(negedge clk);
      n++;
    end
    check("t035_lifetime", n, 20);
    check("t035_misses", 32'(misses), 1);
    check("t035_miss_pulse", 32'(miss_pulse), 1);
    tick(1);
    check("t035_miss_pulse_off", 32'(miss_pulse), 0);

    // Slot exhaustion, duplicate and out-of-range requests.
    do_reset();
    request(1, 2'b00); request(2, 2'b00); request(3, 2'b00); request(4, 2'b00);
    request(6, 2'b00);
    check("t036_four_lit", 32'(ledr), 32'h1E);
    request(3, 2'b00);
    request(20, 2'b00);
    check("t036_ignored", 32'(ledr), 32'h1E);
    check("t036_counters", {score, misses, 8'd0}, 0);

    // Wrong press, then a double hit in one cycle.
    do_reset();
    request(2, 2'b00); request(9, 2'b00);
    sw_r[7] = 1'b1;
    tick(Lat);
    check("t037_wrong_press", 32'(misses), 1);
    sw_r[2] = 1'b1;
    sw_r[9] = 1'b1;
    tick(Lat);
    check("t037_double_hit", 32'(score), 2);
    check("t037_hit_pulse", 32'(hit_pulse), 1);
    check("t037_cleared", 32'(ledr), 0);
    tick(1);
    check("t037_single_pulse", 32'(hit_pulse), 0);

    // Game over via misses, then everything frozen.
    do_reset();
    sw_r[0] = 1'b1;
    sw_r[1] = 1'b1;
    tick(Lat);
    check("t038_two_wrong", 32'(misses), 2);
    sw_r = '0;
    request(10, 2'b01); request(11, 2'b01); request(12, 2'b01);
    n = 0;
    while (n < 40 && !game_over) begin
      @(negedge clk);
      n++;
    end
    check("t038_game_over", 32'(game_over), 1);
    check("t038_misses_max", 32'(misses), MaxM);
    check("t038_ledr_dark", 32'(ledr), 0);
    request(4, 2'b00);
    sw_r[4] = 1'b1;
    sw_r[8] = 1'b1;
    tick(2 + Lat);
    check("t038_frozen_ledr", 32'(ledr), 0);
    check("t038_frozen_counts", {score, misses, 8'd0}, {16'd0, 8'(MaxM), 8'd0});
    do_reset();

    // Random play, focused on low indices so hits are common.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      led_request = ($urandom_range(0, 2) == 0);
      led_index   = $urandom_range(0, 1) ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 23));
      level       = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) begin
        b = $urandom_range(0, 1) ? $urandom_range(0, 5) : $urandom_range(0, Led - 1);
        sw_r[b] = ~sw_r[b];
      end
      if ((game_over && $urandom_range(0, 15) == 0) || $urandom_range(0, 599) == 0) do_reset();
    end
    led_request = 1'b0;
    tick(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
